exe_stage_mc: RTL and testbench
===============================

Name: exe_stage_mc

Overview:
- Parametrised, handshaked execute stage for the RSA ASIP datapath; successor to the single-cycle execute block.
- Adds valid/ready flow control, registered outputs, multi-cycle iterative MUL and MOD, and BEQ/BNE branch resolution.
- Sits between decode/operand-fetch and writeback/fetch-redirect.

Parameters:
- ARQ, 16, datapath width in bits (>=4).
- JADDR_W, 13, jump-address width.
- CNT_W, $clog2(ARQ)+1, iteration-counter width (derived; never overridden).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream offers an instruction.
- in_ready  out  1  stage accepts this cycle.
- alu_op  in  3  0 ADD, 1 SUB, 2 AND, 3 XOR, 4 MUL, 5 MOD, 6 SHL, 7 PASS.
- mux_exe  in  1  operand B select: 0 = srcdest, 1 = imm.
- branch_en  in  1  instruction is a conditional branch.
- branch_ne  in  1  0 = BEQ (taken on zero), 1 = BNE (taken on nonzero).
- src1  in  ARQ  operand A.
- srcdest  in  ARQ  operand B candidate.
- imm  in  ARQ  operand B candidate.
- jaddr  in  JADDR_W  branch target.
- out_valid  out  1  result available.
- out_ready  in  1  downstream consumes the result.
- alu_result  out  ARQ  registered result.
- branch_taken  out  1  registered branch decision, qualified by out_valid.
- jaddr_out  out  JADDR_W  registered branch target.
- busy  out  1  high while in CALC.
- div_by_zero  out  1  MOD issued with B==0, qualified by out_valid.

Behaviour:
- Accept rule: an instruction is accepted on an edge where in_valid && in_ready. All inputs are captured on that edge.
- in_ready = (state==IDLE) || (state==DONE && out_ready).
- Operand B = mux_exe ? imm : srcdest.
- States: IDLE, CALC, DONE.
  - IDLE --accept single-cycle op--> DONE.
  - IDLE --accept MUL/MOD--> CALC.
  - CALC --counter reaches ARQ-1--> DONE.
  - DONE --out_ready, no new accept--> IDLE.
  - DONE --out_ready with accept--> DONE or CALC, chosen by the new op.
- Single-cycle ops (ADD, SUB, AND, XOR, SHL, PASS):
  - out_valid rises on the edge after acceptance; latency 1.
  - Throughput is 1 per cycle while out_ready stays high.
- Arithmetic rules:
  - ADD/SUB wrap modulo 2^ARQ; no carry output.
  - SHL: A << B[CNT_W-2:0]; zero-fill.
  - PASS: result = B.
- MUL: iterative shift-add, one bit per cycle, ARQ iterations. Result = low ARQ bits of A*B, unsigned.
- MOD: restoring remainder, one bit per cycle, ARQ iterations. Result = A mod B, unsigned.
- MUL/MOD timing: accepted at edge N; out_valid rises at edge N+ARQ+1; busy is high for exactly ARQ cycles.
- MOD with B==0:
  - Skips CALC and goes straight to DONE with latency 1.
  - alu_result = A, div_by_zero = 1.
- Branch resolution:
  - zero = (final result == 0).
  - branch_taken = out_valid && branch_en && (zero ^ branch_ne).
  - jaddr_out is the captured jaddr.
  - A branch on a MUL/MOD op resolves at the multi-cycle latency.
- Hold rule: in DONE with out_ready low, alu_result, jaddr_out, branch_taken and div_by_zero stay stable; in_ready = 0.
- Output hold outside DONE: out_valid = 0; branch_taken = 0 and div_by_zero = 0; alu_result and jaddr_out hold their last value.
- Reset (rst low, any state, including mid-CALC):
  - State goes to IDLE; counter and partial products clear.
  - alu_result = 0, jaddr_out = 0, out_valid = 0, branch_taken = 0, busy = 0, div_by_zero = 0.
  - in_ready = 1 on the first cycle after release.
  - The in-flight instruction is discarded.
- Ops 0-7 are all defined; there is no illegal encoding.

Optional Feature:
- Macro: EXE_MOD_EN.
- Defined: MOD is implemented as specified above.
- Undefined:
  - The remainder datapath is removed.
  - Op 5 completes in 1 cycle with alu_result = 0 and div_by_zero = 1, flagging an unsupported op.
  - MUL is unchanged.

Decomposition:
- Package exe_pkg holds:
  - typedef enum logic[2:0] alu_op_t (ADD..PASS);
  - typedef enum logic[1:0] exe_state_t (IDLE, CALC, DONE);
  - localparam ALU_OP_W = 3.
- One natural sub-module: exe_iter_unit. It is the shared shift-add/restoring-remainder engine.
  - Inputs: start, op, A, B.
  - Outputs: done, result.
  - Top level holds the FSM, handshake, operand mux and branch logic.

Test Plan:
- Reset mid-MUL: A=7, B=9; pull rst low 5 cycles after accept -> all outputs 0 and in_ready=1 after release; a new ADD 2+3 returns 5 at latency 1.
- Back-to-back ADD/SUB with out_ready=1: ADD 0xFFFF+1, then SUB 5-5 with branch_en=1, branch_ne=0 -> results 0x0000 then 0x0000; branch_taken=1 on the second only; one result per cycle.
- MUL 0x00FF*0x0101, ARQ=16 -> 0xFFFF; out_valid exactly 17 edges after accept; busy high for 16 cycles.
- MOD 100 mod 7 -> 2. MOD 9 mod 0 -> result 9, div_by_zero=1, latency 1. Without EXE_MOD_EN, op 5 -> result 0, div_by_zero=1.
- Backpressure: hold out_ready=0 for 4 cycles after XOR 0xA5A5^0xFFFF -> 0x5A5A held stable and in_ready=0; on release, a same-cycle accept of the next op completes.
- BNE via mux_exe=1: imm=3, src1=3, SUB, branch_ne=1, jaddr=0x1ABC -> branch_taken=0. Repeat with imm=4 -> branch_taken=1, jaddr_out=0x1ABC.

Source files
------------

// File: rtl/exe_pkg.sv
// Shared types for the handshaked multi-cycle execute stage.
package exe_pkg;

    localparam int ALU_OP_W = 3;

    typedef enum logic [ALU_OP_W-1:0] {
        ALU_ADD  = 3'd0,
        ALU_SUB  = 3'd1,
        ALU_AND  = 3'd2,
        ALU_XOR  = 3'd3,
        ALU_MUL  = 3'd4,
        ALU_MOD  = 3'd5,
        ALU_SHL  = 3'd6,
        ALU_PASS = 3'd7
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } exe_state_t;

endpackage

// File: rtl/exe_stage_mc_if.sv
// Upstream/downstream handshake bundle of the execute stage; master = surrounding pipeline.
interface exe_stage_mc_if #(
    parameter int ARQ     = 16,
    parameter int JADDR_W = 13
);
    logic                          in_valid;
    logic                          in_ready;
    logic [exe_pkg::ALU_OP_W-1:0]  alu_op;
    logic                          mux_exe;
    logic                          branch_en;
    logic                          branch_ne;
    logic [ARQ-1:0]                src1;
    logic [ARQ-1:0]                srcdest;
    logic [ARQ-1:0]                imm;
    logic [JADDR_W-1:0]            jaddr;
    logic                          out_valid;
    logic                          out_ready;
    logic [ARQ-1:0]                alu_result;
    logic                          branch_taken;
    logic [JADDR_W-1:0]            jaddr_out;
    logic                          busy;
    logic                          div_by_zero;

    modport master (
        output in_valid, alu_op, mux_exe, branch_en, branch_ne,
               src1, srcdest, imm, jaddr, out_ready,
        input  in_ready, out_valid, alu_result, branch_taken,
               jaddr_out, busy, div_by_zero
    );

    modport slave (
        input  in_valid, alu_op, mux_exe, branch_en, branch_ne,
               src1, srcdest, imm, jaddr, out_ready,
        output in_ready, out_valid, alu_result, branch_taken,
               jaddr_out, busy, div_by_zero
    );
endinterface

// File: rtl/exe_iter_unit.sv
// Bit-serial engine: shift-add multiply, plus restoring remainder when EXE_MOD_EN is defined.
module exe_iter_unit #(
    parameter int ARQ = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start_i,
    input  logic           op_mod_i,
    input  logic [ARQ-1:0] a_i,
    input  logic [ARQ-1:0] b_i,
    output logic           done_o,
    output logic           busy_o,
    output logic [ARQ-1:0] result_o
);
    localparam int CNT_W = $clog2(ARQ) + 1;

    logic [ARQ-1:0]   acc_q, acc_d;
    logic [ARQ-1:0]   x_q, x_d;
    logic [ARQ-1:0]   y_q, y_d;
    logic [CNT_W-1:0] cnt_q;
    logic             run_q;
    logic             done_q;
`ifdef EXE_MOD_EN
    logic             mod_q;
    logic [ARQ:0]     rem_t_s;
`else
    logic             unused_op_s;
    assign unused_op_s = op_mod_i;
`endif

    // One iteration: x is the shifting multiplicand / dividend, y the multiplier / divisor.
    always_comb begin
        acc_d = acc_q;
        x_d   = x_q;
        y_d   = y_q;
`ifdef EXE_MOD_EN
        rem_t_s = {acc_q, x_q[ARQ-1]};
        if (mod_q) begin
            x_d = {x_q[ARQ-2:0], 1'b0};
            if (rem_t_s >= {1'b0, y_q}) begin
                acc_d = ARQ'(rem_t_s - {1'b0, y_q});
            end else begin
                acc_d = rem_t_s[ARQ-1:0];
            end
        end else
`endif
        begin
            if (y_q[0]) begin
                acc_d = acc_q + x_q;
            end else begin
                acc_d = acc_q;
            end
            x_d = {x_q[ARQ-2:0], 1'b0};
            y_d = {1'b0, y_q[ARQ-1:1]};
        end
    end

    // Operand load on start, then ARQ iterations with a one-cycle done pulse after the last.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q  <= {ARQ{1'b0}};
            x_q    <= {ARQ{1'b0}};
            y_q    <= {ARQ{1'b0}};
            cnt_q  <= {CNT_W{1'b0}};
            run_q  <= 1'b0;
            done_q <= 1'b0;
`ifdef EXE_MOD_EN
            mod_q  <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            if (start_i) begin
                acc_q <= {ARQ{1'b0}};
                x_q   <= a_i;
                y_q   <= b_i;
                cnt_q <= {CNT_W{1'b0}};
                run_q <= 1'b1;
`ifdef EXE_MOD_EN
                mod_q <= op_mod_i;
`endif
            end else if (run_q) begin
                acc_q <= acc_d;
                x_q   <= x_d;
                y_q   <= y_d;
                if (cnt_q == CNT_W'(ARQ - 1)) begin
                    cnt_q  <= {CNT_W{1'b0}};
                    run_q  <= 1'b0;
                    done_q <= 1'b1;
                end else begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end else begin
                run_q <= 1'b0;
            end
        end
    end

    assign done_o   = done_q;
    assign busy_o   = run_q;
    assign result_o = acc_q;
endmodule

// File: rtl/exe_stage_mc.sv
// Handshaked execute stage with iterative MUL/MOD and BEQ/BNE resolution.
// Optional remainder datapath enabled by the EXE_MOD_EN macro.
module exe_stage_mc
    import exe_pkg::*;
#(
    parameter int ARQ     = 16,
    parameter int JADDR_W = 13
) (
    input  logic              clk,
    input  logic              rst,
    exe_stage_mc_if.slave     bus
);
    localparam int CNT_W = $clog2(ARQ) + 1;
    localparam int SH_W  = CNT_W - 1;

    exe_state_t         state_q;
    logic [ARQ-1:0]     alu_result_q;
    logic [JADDR_W-1:0] jaddr_out_q;
    logic               branch_taken_q;
    logic               div_by_zero_q;
    logic               pend_en_q;
    logic               pend_ne_q;
    logic [JADDR_W-1:0] pend_jaddr_q;

    alu_op_t            op_s;
    logic [ARQ-1:0]     opb_s;
    logic [ARQ-1:0]     res_s;
    logic               dbz_s;
    logic               multi_s;
    logic               in_ready_s;
    logic               accept_s;
    logic               start_s;
    logic               op_mod_s;
    logic               br_s;
    logic               iter_done_s;
    logic               iter_busy_s;
    logic [ARQ-1:0]     iter_res_s;

    assign op_s       = alu_op_t'(bus.alu_op);
    assign opb_s      = bus.mux_exe ? bus.imm : bus.srcdest;
    assign in_ready_s = (state_q == IDLE) || ((state_q == DONE) && bus.out_ready);
    assign accept_s   = bus.in_valid && in_ready_s;
    assign start_s    = accept_s && multi_s;
    assign op_mod_s   = (op_s == ALU_MOD);
    assign br_s       = bus.branch_en && ((res_s == {ARQ{1'b0}}) ^ bus.branch_ne);

    // Single-cycle result and decision on whether the op needs the iterative engine.
    always_comb begin
        res_s   = {ARQ{1'b0}};
        dbz_s   = 1'b0;
        multi_s = 1'b0;
        case (op_s)
            ALU_ADD:  res_s = bus.src1 + opb_s;
            ALU_SUB:  res_s = bus.src1 - opb_s;
            ALU_AND:  res_s = bus.src1 & opb_s;
            ALU_XOR:  res_s = bus.src1 ^ opb_s;
            ALU_SHL:  res_s = bus.src1 << opb_s[SH_W-1:0];
            ALU_PASS: res_s = opb_s;
            ALU_MUL:  multi_s = 1'b1;
            ALU_MOD: begin
`ifdef EXE_MOD_EN
                if (opb_s == {ARQ{1'b0}}) begin
                    res_s = bus.src1;
                    dbz_s = 1'b1;
                end else begin
                    multi_s = 1'b1;
                end
`else
                dbz_s = 1'b1;
`endif
            end
            default:  res_s = {ARQ{1'b0}};
        endcase
    end

    exe_iter_unit #(.ARQ(ARQ)) u_iter (
        .clk      (clk),
        .rst      (rst),
        .start_i  (start_s),
        .op_mod_i (op_mod_s),
        .a_i      (bus.src1),
        .b_i      (opb_s),
        .done_o   (iter_done_s),
        .busy_o   (iter_busy_s),
        .result_o (iter_res_s)
    );

    // Control FSM; result/branch registers only change when an op completes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= IDLE;
            alu_result_q   <= {ARQ{1'b0}};
            jaddr_out_q    <= {JADDR_W{1'b0}};
            branch_taken_q <= 1'b0;
            div_by_zero_q  <= 1'b0;
            pend_en_q      <= 1'b0;
            pend_ne_q      <= 1'b0;
            pend_jaddr_q   <= {JADDR_W{1'b0}};
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (accept_s && multi_s) begin
                        state_q        <= CALC;
                        branch_taken_q <= 1'b0;
                        div_by_zero_q  <= 1'b0;
                        pend_en_q      <= bus.branch_en;
                        pend_ne_q      <= bus.branch_ne;
                        pend_jaddr_q   <= bus.jaddr;
                    end else if (accept_s) begin
                        state_q        <= DONE;
                        alu_result_q   <= res_s;
                        jaddr_out_q    <= bus.jaddr;
                        branch_taken_q <= br_s;
                        div_by_zero_q  <= dbz_s;
                    end else if ((state_q == DONE) && bus.out_ready) begin
                        state_q        <= IDLE;
                        branch_taken_q <= 1'b0;
                        div_by_zero_q  <= 1'b0;
                    end else begin
                        state_q <= state_q;
                    end
                end
                CALC: begin
                    if (iter_done_s) begin
                        state_q        <= DONE;
                        alu_result_q   <= iter_res_s;
                        jaddr_out_q    <= pend_jaddr_q;
                        branch_taken_q <= pend_en_q &&
                                          ((iter_res_s == {ARQ{1'b0}}) ^ pend_ne_q);
                        div_by_zero_q  <= 1'b0;
                    end else begin
                        state_q <= CALC;
                    end
                end
                default: begin
                    state_q        <= IDLE;
                    branch_taken_q <= 1'b0;
                    div_by_zero_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready     = in_ready_s;
    assign bus.out_valid    = (state_q == DONE);
    assign bus.alu_result   = alu_result_q;
    assign bus.jaddr_out    = jaddr_out_q;
    assign bus.branch_taken = branch_taken_q;
    assign bus.div_by_zero  = div_by_zero_q;
    assign bus.busy         = iter_busy_s;
endmodule

// File: tb/tb_exe_stage_mc.sv
// Directed bench for exe_stage_mc: vector table plus reset, back-to-back and backpressure sequences.
module tb_exe_stage_mc;
    import exe_pkg::*;

    localparam int ARQ = 16;
    localparam int JW  = 13;
`ifdef EXE_MOD_EN
    localparam bit MOD_ON = 1'b1;
`else
    localparam bit MOD_ON = 1'b0;
`endif

    logic clk;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    exe_stage_mc_if #(.ARQ(ARQ), .JADDR_W(JW)) bus ();

    exe_stage_mc #(.ARQ(ARQ), .JADDR_W(JW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [2:0]  op;
        logic        mux;
        logic        ben;
        logic        bne;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] imm;
        logic [12:0] ja;
        logic [15:0] res;
        logic        bt;
        logic        dbz;
        int          edges;
        int          busy;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [2:0] op, input logic mux, input logic ben,
                                input logic bne, input logic [15:0] a, input logic [15:0] b,
                                input logic [15:0] imm, input logic [12:0] ja,
                                input logic [15:0] res, input logic bt, input logic dbz,
                                input int edges, input int busy);
        vec_t v;
        v.op = op; v.mux = mux; v.ben = ben; v.bne = bne;
        v.a = a; v.b = b; v.imm = imm; v.ja = ja;
        v.res = res; v.bt = bt; v.dbz = dbz; v.edges = edges; v.busy = busy;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.alu_op    = v.op;
        bus.mux_exe   = v.mux;
        bus.branch_en = v.ben;
        bus.branch_ne = v.bne;
        bus.src1      = v.a;
        bus.srcdest   = v.b;
        bus.imm       = v.imm;
        bus.jaddr     = v.ja;
    endtask

    // Issue one op from IDLE, wait (bounded) for the result, check it and the idle hold after it.
    task automatic run_vec(input vec_t v, input string tag);
        int   edges;
        int   bcnt;
        logic rdy0;
        drive(v);
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        edges = 0;
        bcnt  = 0;
        rdy0  = bus.in_ready;
        while (!bus.out_valid && edges < 40) begin
            if (bus.busy) bcnt++;
            @(posedge clk); #1;
            edges++;
        end
        chk({tag, "_edges"}, 32'(edges), 32'(v.edges));
        chk({tag, "_busy_cycles"}, 32'(bcnt), 32'(v.busy));
        chk({tag, "_result"}, 32'(bus.alu_result), 32'(v.res));
        chk({tag, "_branch"}, 32'(bus.branch_taken), 32'(v.bt));
        chk({tag, "_jaddr"}, 32'(bus.jaddr_out), 32'(v.ja));
        chk({tag, "_dbz"}, 32'(bus.div_by_zero), 32'(v.dbz));
        if (v.edges > 0) chk({tag, "_ready_in_calc"}, 32'(rdy0), 32'(0));
        @(posedge clk); #1;
        chk({tag, "_idle_valid"}, 32'(bus.out_valid), 32'(0));
        chk({tag, "_idle_branch"}, 32'(bus.branch_taken), 32'(0));
        chk({tag, "_idle_dbz"}, 32'(bus.div_by_zero), 32'(0));
        chk({tag, "_idle_hold"}, 32'(bus.alu_result), 32'(v.res));
    endtask

    initial begin
        int   seen;
        vec_t v;

        rst = 1'b0;
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        bus.alu_op = 3'd0; bus.mux_exe = 1'b0; bus.branch_en = 1'b0; bus.branch_ne = 1'b0;
        bus.src1 = 16'h0; bus.srcdest = 16'h0; bus.imm = 16'h0; bus.jaddr = 13'h0;

        // op, mux, ben, bne, a, b, imm, ja, res, bt, dbz, edges, busy
        vecs.push_back(mk(ALU_ADD,  1'b0, 1'b0, 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 13'h0101, 16'h0000, 1'b0, 1'b0, 0, 0));
        vecs.push_back(mk(ALU_SUB,  1'b0, 1'b1, 1'b0, 16'h0005, 16'h0005, 16'h0000, 13'h0102, 16'h0000, 1'b1, 1'b0, 0, 0));
        vecs.push_back(mk(ALU_AND,  1'b0, 1'b0, 1'b0, 16'hF0F0, 16'h3C3C, 16'h0000, 13'h0103, 16'h3030, 1'b0, 1'b0, 0, 0));
        vecs.push_back(mk(ALU_XOR,  1'b1, 1'b0, 1'b0, 16'hA5A5, 16'h0000, 16'hFFFF, 13'h0104, 16'h5A5A, 1'b0, 1'b0, 0, 0));
        vecs.push_back(mk(ALU_SHL,  1'b0, 1'b0, 1'b0, 16'h0001, 16'h0013, 16'h0000, 13'h0105, 16'h0008, 1'b0, 1'b0, 0, 0));
        vecs.push_back(mk(ALU_SHL,  1'b0, 1'b0, 1'b0, 16'h8001, 16'h000F, 16'h0000, 13'h0106, 16'h8000, 1'b0, 1'b0, 0, 0));
        vecs.push_back(mk(ALU_PASS, 1'b1, 1'b0, 1'b0, 16'h1111, 16'h1234, 16'hBEEF, 13'h0107, 16'hBEEF, 1'b0, 1'b0, 0, 0));
        vecs.push_back(mk(ALU_MUL,  1'b0, 1'b0, 1'b0, 16'h00FF, 16'h0101, 16'h0000, 13'h0108, 16'hFFFF, 1'b0, 1'b0, 17, 16));
        vecs.push_back(mk(ALU_MUL,  1'b1, 1'b1, 1'b1, 16'h1234, 16'h0000, 16'h0010, 13'h0F0F, 16'h2340, 1'b1, 1'b0, 17, 16));
        vecs.push_back(mk(ALU_MUL,  1'b0, 1'b1, 1'b0, 16'hFFFF, 16'hFFFF, 16'h0000, 13'h010A, 16'h0001, 1'b0, 1'b0, 17, 16));
        if (MOD_ON) begin
            vecs.push_back(mk(ALU_MOD, 1'b0, 1'b0, 1'b0, 16'd100,   16'd7,    16'h0000, 13'h010B, 16'h0002, 1'b0, 1'b0, 17, 16));
            vecs.push_back(mk(ALU_MOD, 1'b0, 1'b0, 1'b0, 16'd9,     16'd0,    16'h0000, 13'h010C, 16'h0009, 1'b0, 1'b1, 0, 0));
            vecs.push_back(mk(ALU_MOD, 1'b0, 1'b1, 1'b0, 16'hFFFF, 16'h00FF, 16'h0000, 13'h010D, 16'h0000, 1'b1, 1'b0, 17, 16));
            vecs.push_back(mk(ALU_MOD, 1'b1, 1'b0, 1'b0, 16'h1234, 16'h0000, 16'h1235, 13'h010E, 16'h1234, 1'b0, 1'b0, 17, 16));
        end else begin
            vecs.push_back(mk(ALU_MOD, 1'b0, 1'b0, 1'b0, 16'd100,   16'd7,    16'h0000, 13'h010B, 16'h0000, 1'b0, 1'b1, 0, 0));
            vecs.push_back(mk(ALU_MOD, 1'b0, 1'b0, 1'b0, 16'd9,     16'd0,    16'h0000, 13'h010C, 16'h0000, 1'b0, 1'b1, 0, 0));
            vecs.push_back(mk(ALU_MOD, 1'b0, 1'b1, 1'b0, 16'hFFFF, 16'h00FF, 16'h0000, 13'h010D, 16'h0000, 1'b1, 1'b1, 0, 0));
            vecs.push_back(mk(ALU_MOD, 1'b1, 1'b0, 1'b0, 16'h1234, 16'h0000, 16'h1235, 13'h010E, 16'h0000, 1'b0, 1'b1, 0, 0));
        end
        vecs.push_back(mk(ALU_SUB, 1'b1, 1'b1, 1'b1, 16'h0003, 16'h0000, 16'h0003, 13'h1ABC, 16'h0000, 1'b0, 1'b0, 0, 0));
        vecs.push_back(mk(ALU_SUB, 1'b1, 1'b1, 1'b1, 16'h0003, 16'h0000, 16'h0004, 13'h1ABC, 16'hFFFF, 1'b1, 1'b0, 0, 0));

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 32'(bus.out_valid), 32'(0));
        chk("rst_result", 32'(bus.alu_result), 32'(0));
        chk("rst_jaddr", 32'(bus.jaddr_out), 32'(0));
        chk("rst_branch", 32'(bus.branch_taken), 32'(0));
        chk("rst_busy", 32'(bus.busy), 32'(0));
        chk("rst_dbz", 32'(bus.div_by_zero), 32'(0));
        chk("rst_ready", 32'(bus.in_ready), 32'(1));
        rst = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_ready", 32'(bus.in_ready), 32'(1));

        foreach (vecs[i]) run_vec(vecs[i], $sformatf("v%0d", i));

        // Back-to-back single-cycle ops with out_ready held high
        drive(mk(ALU_ADD, 1'b0, 1'b0, 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 13'h0201, 16'h0, 1'b0, 1'b0, 0, 0));
        bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        @(posedge clk); #1;
        chk("b2b_first_valid", 32'(bus.out_valid), 32'(1));
        chk("b2b_first_result", 32'(bus.alu_result), 32'(16'h0000));
        chk("b2b_first_branch", 32'(bus.branch_taken), 32'(0));
        chk("b2b_ready", 32'(bus.in_ready), 32'(1));
        drive(mk(ALU_SUB, 1'b0, 1'b1, 1'b0, 16'h0005, 16'h0005, 16'h0000, 13'h0202, 16'h0, 1'b0, 1'b0, 0, 0));
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        chk("b2b_second_valid", 32'(bus.out_valid), 32'(1));
        chk("b2b_second_result", 32'(bus.alu_result), 32'(16'h0000));
        chk("b2b_second_branch", 32'(bus.branch_taken), 32'(1));
        chk("b2b_second_jaddr", 32'(bus.jaddr_out), 32'(13'h0202));
        @(posedge clk); #1;
        chk("b2b_idle", 32'(bus.out_valid), 32'(0));

        // Backpressure: result held while out_ready low, next op waits
        bus.out_ready = 1'b0;
        drive(mk(ALU_XOR, 1'b1, 1'b0, 1'b0, 16'hA5A5, 16'h0000, 16'hFFFF, 13'h0301, 16'h0, 1'b0, 1'b0, 0, 0));
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        chk("bp_result", 32'(bus.alu_result), 32'(16'h5A5A));
        chk("bp_ready_low", 32'(bus.in_ready), 32'(0));
        drive(mk(ALU_ADD, 1'b0, 1'b0, 1'b0, 16'h0001, 16'h0001, 16'h0000, 13'h0302, 16'h0, 1'b0, 1'b0, 0, 0));
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            chk($sformatf("bp_hold_result_%0d", k), 32'(bus.alu_result), 32'(16'h5A5A));
            chk($sformatf("bp_hold_valid_%0d", k), 32'(bus.out_valid), 32'(1));
            chk($sformatf("bp_hold_ready_%0d", k), 32'(bus.in_ready), 32'(0));
            chk($sformatf("bp_hold_jaddr_%0d", k), 32'(bus.jaddr_out), 32'(13'h0301));
        end
        bus.out_ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(bus.in_ready), 32'(1));
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        chk("bp_next_result", 32'(bus.alu_result), 32'(16'h0002));
        chk("bp_next_valid", 32'(bus.out_valid), 32'(1));
        chk("bp_next_jaddr", 32'(bus.jaddr_out), 32'(13'h0302));
        @(posedge clk); #1;
        chk("bp_idle", 32'(bus.out_valid), 32'(0));

        // Reset in the middle of a MUL discards it
        drive(mk(ALU_MUL, 1'b0, 1'b0, 1'b0, 16'd7, 16'd9, 16'h0000, 13'h0401, 16'h0, 1'b0, 1'b0, 0, 0));
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("mid_busy", 32'(bus.busy), 32'(1));
        rst = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(bus.out_valid), 32'(0));
        chk("mid_rst_result", 32'(bus.alu_result), 32'(0));
        chk("mid_rst_jaddr", 32'(bus.jaddr_out), 32'(0));
        chk("mid_rst_busy", 32'(bus.busy), 32'(0));
        chk("mid_rst_branch", 32'(bus.branch_taken), 32'(0));
        chk("mid_rst_dbz", 32'(bus.div_by_zero), 32'(0));
        @(posedge clk); #1;
        rst = 1'b1;
        chk("mid_rel_ready", 32'(bus.in_ready), 32'(1));
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (bus.out_valid || bus.busy) seen++;
        end
        chk("mid_no_stale_result", 32'(seen), 32'(0));
        v = mk(ALU_ADD, 1'b0, 1'b0, 1'b0, 16'd2, 16'd3, 16'h0000, 13'h0402, 16'h0005, 1'b0, 1'b0, 0, 0);
        run_vec(v, "after_rst_add");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
